// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: shared types and helpers for the waveform generator.
//   mode_e   waveform shape selected by cfg_mode
//   dir_e    direction of the internal sample counter
//   start_dir  counter direction at the start of a period for a given mode
// The config record (mode/lo/hi/step) depends on the WIDTH parameter of
// the instantiating module, so each module declares its own packed cfg_t.
package wave_gen_pkg;

   typedef enum logic [1:0] {
      TRI      = 2'd0,
      SAW_UP   = 2'd1,
      SAW_DOWN = 2'd2,
      SQUARE   = 2'd3
   } mode_e;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_LO_VAL = 0;
   localparam int DEF_HI_VAL = 127;
   localparam int DEF_STEP_VAL = 1;

   function automatic dir_e start_dir(input mode_e mode);
      return (mode == SAW_DOWN) ? DOWN : UP;
   endfunction

endpackage

// File: rtl/wave_cfg_shadow.sv
// wave_cfg_shadow: config handshake with validation, a one-deep pending
// slot and the active config register.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cfg_valid/cfg_ready     request handshake; ready is low while a config is pending
//   cfg_mode/lo/hi/step     requested config
//   apply                   from the counter: move pending into active this cycle
//   cfg_err                 one-cycle pulse when an accepted request is malformed
//   pend_valid/mode/lo/hi   pending config, used by the counter to load the new start value
//   act_mode/lo/hi/step     active config driving the counter
module wave_cfg_shadow
   import wave_gen_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEF_LO   = DEF_LO_VAL,
   parameter int DEF_HI   = DEF_HI_VAL,
   parameter int DEF_STEP = DEF_STEP_VAL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_mode,
   input  logic [WIDTH-1:0] cfg_lo,
   input  logic [WIDTH-1:0] cfg_hi,
   input  logic [WIDTH-1:0] cfg_step,
   input  logic             apply,
   output logic             cfg_err,
   output logic             pend_valid,
   output mode_e            pend_mode,
   output logic [WIDTH-1:0] pend_lo,
   output logic [WIDTH-1:0] pend_hi,
   output mode_e            act_mode,
   output logic [WIDTH-1:0] act_lo,
   output logic [WIDTH-1:0] act_hi,
   output logic [WIDTH-1:0] act_step
);

   typedef struct packed {
      mode_e            mode;
      logic [WIDTH-1:0] lo;
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] step;
   } cfg_t;

   cfg_t act_q, act_d;
   cfg_t pend_q, pend_d;
   logic pend_valid_q, pend_valid_d;
   logic err_q, err_d;
   logic req_ok;

   always_comb begin
      act_d        = act_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      err_d        = 1'b0;
      req_ok       = (cfg_lo < cfg_hi) && (cfg_step != '0);

      // apply needs a pending entry and accept needs an empty slot, so the
      // two never fire in the same cycle.
      if (apply) begin
         act_d        = pend_q;
         pend_valid_d = 1'b0;
      end

      if (cfg_valid && !pend_valid_q) begin
         if (req_ok) begin
            pend_d       = '{mode: mode_e'(cfg_mode), lo: cfg_lo, hi: cfg_hi, step: cfg_step};
            pend_valid_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         act_q        <= '{mode: TRI, lo: WIDTH'(DEF_LO), hi: WIDTH'(DEF_HI), step: WIDTH'(DEF_STEP)};
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         act_q        <= act_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         err_q        <= err_d;
      end
   end

   assign cfg_ready  = ~pend_valid_q;
   assign cfg_err    = err_q;
   assign pend_valid = pend_valid_q;
   assign pend_mode  = pend_q.mode;
   assign pend_lo    = pend_q.lo;
   assign pend_hi    = pend_q.hi;
   assign act_mode   = act_q.mode;
   assign act_lo     = act_q.lo;
   assign act_hi     = act_q.hi;
   assign act_step   = act_q.step;

endmodule

// File: rtl/wave_gen.sv
// wave_gen: parametrised waveform generator (triangle, sawtooth up/down,
// square) with programmable floor, ceiling and step.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   en                    advance one step per cycle when high, hold when low
//   cfg_valid/cfg_ready   config handshake
//   cfg_mode/lo/hi/step   requested config
//   cfg_err               one-cycle pulse on a rejected request
//   wave                  current sample
//   count_down            counter direction, 1 = descending
//   period_pulse          one-cycle pulse when wave loads the period start value
//
// Direction FSM:
//   state | meaning
//   UP    | counter ascending towards hi
//   DOWN  | counter descending towards lo
module wave_gen
   import wave_gen_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEF_LO   = DEF_LO_VAL,
   parameter int DEF_HI   = DEF_HI_VAL,
   parameter int DEF_STEP = DEF_STEP_VAL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_mode,
   input  logic [WIDTH-1:0] cfg_lo,
   input  logic [WIDTH-1:0] cfg_hi,
   input  logic [WIDTH-1:0] cfg_step,
   output logic             cfg_err,
   output logic [WIDTH-1:0] wave,
   output logic             count_down,
   output logic             period_pulse
);

   logic [WIDTH-1:0] c_q, c_d;
   logic [WIDTH-1:0] wave_q, wave_d;
   dir_e             dir_q, dir_d;
   logic             pulse_q, pulse_d;

   logic             pend_valid;
   mode_e            pend_mode, act_mode, sel_mode;
   logic [WIDTH-1:0] pend_lo, pend_hi;
   logic [WIDTH-1:0] act_lo, act_hi, act_step;
   logic [WIDTH-1:0] sel_lo, sel_hi;

   logic             apply;
   logic             bnd;
   logic [WIDTH-1:0] nxt_c;
   dir_e             nxt_dir;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   lo_step;

   wave_cfg_shadow #(
      .WIDTH    (WIDTH),
      .DEF_LO   (DEF_LO),
      .DEF_HI   (DEF_HI),
      .DEF_STEP (DEF_STEP)
   ) u_shadow (
      .clk        (clk),
      .reset      (reset),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_mode   (cfg_mode),
      .cfg_lo     (cfg_lo),
      .cfg_hi     (cfg_hi),
      .cfg_step   (cfg_step),
      .apply      (apply),
      .cfg_err    (cfg_err),
      .pend_valid (pend_valid),
      .pend_mode  (pend_mode),
      .pend_lo    (pend_lo),
      .pend_hi    (pend_hi),
      .act_mode   (act_mode),
      .act_lo     (act_lo),
      .act_hi     (act_hi),
      .act_step   (act_step)
   );

   always_comb begin
      // One extra bit so neither the step sum nor lo+step can wrap.
      up_sum  = {1'b0, c_q} + {1'b0, act_step};
      lo_step = {1'b0, act_lo} + {1'b0, act_step};
      nxt_c   = c_q;
      nxt_dir = dir_q;
      bnd     = 1'b0;

      case (act_mode)
         SAW_UP: begin
            nxt_dir = UP;
            if (c_q >= act_hi) begin
               nxt_c = act_lo;
               bnd   = 1'b1;
            end else if (up_sum >= {1'b0, act_hi}) begin
               nxt_c = act_hi;
            end else begin
               nxt_c = up_sum[WIDTH-1:0];
            end
         end
         SAW_DOWN: begin
            nxt_dir = DOWN;
            if (c_q <= act_lo) begin
               nxt_c = act_hi;
               bnd   = 1'b1;
            end else if ({1'b0, c_q} <= lo_step) begin
               nxt_c = act_lo;
            end else begin
               nxt_c = c_q - act_step;
            end
         end
         default: begin
            // TRI and SQUARE share the triangle counter. Landing exactly on
            // lo+step clamps to lo so the floor is held for one cycle only,
            // mirroring the ceiling.
            if (dir_q == UP) begin
               if (up_sum >= {1'b0, act_hi}) begin
                  nxt_c   = act_hi;
                  nxt_dir = DOWN;
               end else begin
                  nxt_c = up_sum[WIDTH-1:0];
               end
            end else begin
               if ({1'b0, c_q} <= lo_step) begin
                  nxt_c   = act_lo;
                  nxt_dir = UP;
                  bnd     = 1'b1;
               end else begin
                  nxt_c = c_q - act_step;
               end
            end
         end
      endcase

      // While disabled there is no boundary to wait for, so a pending
      // config goes live on the next clock.
      apply = pend_valid & (~en | bnd);

      c_d      = c_q;
      dir_d    = dir_q;
      pulse_d  = 1'b0;
      sel_mode = act_mode;
      sel_lo   = act_lo;
      sel_hi   = act_hi;

      if (apply) begin
         sel_mode = pend_mode;
         sel_lo   = pend_lo;
         sel_hi   = pend_hi;
         c_d      = (pend_mode == SAW_DOWN) ? pend_hi : pend_lo;
         dir_d    = start_dir(pend_mode);
         pulse_d  = en;
      end else if (en) begin
         c_d     = nxt_c;
         dir_d   = nxt_dir;
         pulse_d = bnd;
      end

      wave_d = (sel_mode == SQUARE) ? ((dir_d == DOWN) ? sel_lo : sel_hi) : c_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c_q     <= WIDTH'(DEF_LO);
         wave_q  <= WIDTH'(DEF_LO);
         dir_q   <= UP;
         pulse_q <= 1'b0;
      end else begin
         c_q     <= c_d;
         wave_q  <= wave_d;
         dir_q   <= dir_d;
         pulse_q <= pulse_d;
      end
   end

   assign wave         = wave_q;
   assign count_down   = (dir_q == DOWN);
   assign period_pulse = pulse_q;

endmodule

// File: tb/tb_wave_gen.sv
module tb_wave_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [1:0] cfg_mode;
   logic [7:0] cfg_lo, cfg_hi, cfg_step;
   logic       cfg_err;
   logic [7:0] wave;
   logic       count_down;
   logic       period_pulse;

   int checks = 0;
   int errors = 0;

   wave_gen dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_mode     (cfg_mode),
      .cfg_lo       (cfg_lo),
      .cfg_hi       (cfg_hi),
      .cfg_step     (cfg_step),
      .cfg_err      (cfg_err),
      .wave         (wave),
      .count_down   (count_down),
      .period_pulse (period_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic       vld;
      logic [1:0] mode;
      logic [7:0] lo;
      logic [7:0] hi;
      logic [7:0] step;
      logic [7:0] w;
      logic       cd;
      logic       p;
      logic       rdy;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic e, input logic v, input logic [1:0] m,
                               input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] st,
                               input logic [7:0] w, input logic cd, input logic p,
                               input logic rdy, input logic err);
      vec_t r;
      r.en = e; r.vld = v; r.mode = m; r.lo = lo; r.hi = hi; r.step = st;
      r.w = w; r.cd = cd; r.p = p; r.rdy = rdy; r.err = err;
      return r;
   endfunction

   // idle row: enable given, no request
   function automatic vec_t idl(input logic e, input logic [7:0] w, input logic cd,
                                input logic p, input logic rdy);
      return mk(e, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, w, cd, p, rdy, 1'b0);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // default triangle 0..127..1, period 254, t = enabled cycles since reset
   function automatic int dflt_w(input int t);
      int ph;
      ph = t % 254;
      return (ph <= 127) ? ph : 254 - ph;
   endfunction

   function automatic int dflt_cd(input int t);
      return ((t % 254) >= 127) ? 1 : 0;
   endfunction

   function automatic int dflt_p(input int t);
      return ((t % 254) == 0) ? 1 : 0;
   endfunction

   initial begin
      reset = 1'b1; en = 1'b0; cfg_valid = 1'b0;
      cfg_mode = 2'd0; cfg_lo = 8'd0; cfg_hi = 8'd0; cfg_step = 8'd0;
      step();
      step();
      chk("reset_wave", wave, 0);
      chk("reset_cd", count_down, 0);
      chk("reset_pulse", period_pulse, 0);
      chk("reset_ready", cfg_ready, 1);
      chk("reset_err", cfg_err, 0);

      // Default triangle, with a TRI 10/20/3 request accepted mid-period
      // that must wait for the old period to finish.
      reset = 1'b0;
      en    = 1'b1;
      for (int t = 1; t <= 761; t++) begin
         if (t == 558) begin
            cfg_valid = 1'b1; cfg_mode = 2'd0;
            cfg_lo = 8'd10; cfg_hi = 8'd20; cfg_step = 8'd3;
         end else begin
            cfg_valid = 1'b0;
         end
         step();
         chk("dflt_wave", wave, dflt_w(t));
         chk("dflt_cd", count_down, dflt_cd(t));
         chk("dflt_pulse", period_pulse, dflt_p(t));
         chk("dflt_ready", cfg_ready, (t >= 558) ? 0 : 1);
      end

      // en, vld, mode, lo, hi, step -> wave, cd, pulse, ready, err
      vecs.push_back(idl(1, 10, 0, 1, 1));
      vecs.push_back(idl(1, 13, 0, 0, 1));
      vecs.push_back(idl(1, 16, 0, 0, 1));
      vecs.push_back(idl(1, 19, 0, 0, 1));
      vecs.push_back(idl(1, 20, 1, 0, 1));
      vecs.push_back(idl(1, 17, 1, 0, 1));
      for (int i = 0; i < 5; i++) vecs.push_back(idl(0, 17, 1, 0, 1));
      vecs.push_back(idl(1, 14, 1, 0, 1));
      vecs.push_back(idl(1, 11, 1, 0, 1));
      vecs.push_back(idl(1, 10, 0, 1, 1));
      // SAW_UP 0/9/4 requested, applied at the next TRI boundary
      vecs.push_back(mk(1, 1, 2'd1, 0, 9, 4, 13, 0, 0, 0, 0));
      vecs.push_back(idl(1, 16, 0, 0, 0));
      vecs.push_back(idl(1, 19, 0, 0, 0));
      vecs.push_back(idl(1, 20, 1, 0, 0));
      vecs.push_back(idl(1, 17, 1, 0, 0));
      vecs.push_back(idl(1, 14, 1, 0, 0));
      vecs.push_back(idl(1, 11, 1, 0, 0));
      vecs.push_back(idl(1, 0, 0, 1, 1));
      vecs.push_back(idl(1, 4, 0, 0, 1));
      vecs.push_back(idl(1, 8, 0, 0, 1));
      vecs.push_back(idl(1, 9, 0, 0, 1));
      vecs.push_back(idl(1, 0, 0, 1, 1));
      // SQUARE 0/9/4
      vecs.push_back(mk(1, 1, 2'd3, 0, 9, 4, 4, 0, 0, 0, 0));
      vecs.push_back(idl(1, 8, 0, 0, 0));
      vecs.push_back(idl(1, 9, 0, 0, 0));
      vecs.push_back(idl(1, 9, 0, 1, 1));
      vecs.push_back(idl(1, 9, 0, 0, 1));
      vecs.push_back(idl(1, 9, 0, 0, 1));
      vecs.push_back(idl(1, 0, 1, 0, 1));
      vecs.push_back(idl(1, 0, 1, 0, 1));
      vecs.push_back(idl(1, 0, 1, 0, 1));
      vecs.push_back(idl(1, 9, 0, 1, 1));
      // rejected requests: lo==hi, step==0, lo>hi
      vecs.push_back(mk(1, 1, 2'd0, 50, 50, 1, 9, 0, 0, 1, 1));
      vecs.push_back(idl(1, 9, 0, 0, 1));
      vecs.push_back(mk(1, 1, 2'd0, 1, 5, 0, 0, 1, 0, 1, 1));
      vecs.push_back(mk(1, 1, 2'd0, 9, 3, 1, 0, 1, 0, 1, 1));
      vecs.push_back(idl(1, 0, 1, 0, 1));
      vecs.push_back(idl(1, 9, 0, 1, 1));
      vecs.push_back(idl(1, 9, 0, 0, 1));
      vecs.push_back(idl(1, 9, 0, 0, 1));
      vecs.push_back(idl(1, 0, 1, 0, 1));
      vecs.push_back(idl(1, 0, 1, 0, 1));
      // accept while disabled: applies the following cycle, no pulse
      vecs.push_back(mk(0, 1, 2'd0, 10, 20, 3, 0, 1, 0, 0, 0));
      vecs.push_back(idl(0, 10, 0, 0, 1));
      vecs.push_back(idl(0, 10, 0, 0, 1));
      vecs.push_back(idl(1, 13, 0, 0, 1));
      // SAW_DOWN 2/8/3
      vecs.push_back(mk(1, 1, 2'd2, 2, 8, 3, 16, 0, 0, 0, 0));
      vecs.push_back(idl(1, 19, 0, 0, 0));
      vecs.push_back(idl(1, 20, 1, 0, 0));
      vecs.push_back(idl(1, 17, 1, 0, 0));
      vecs.push_back(idl(1, 14, 1, 0, 0));
      vecs.push_back(idl(1, 11, 1, 0, 0));
      vecs.push_back(idl(1, 8, 1, 1, 1));
      vecs.push_back(idl(1, 5, 1, 0, 1));
      vecs.push_back(idl(1, 2, 1, 0, 1));
      vecs.push_back(idl(1, 8, 1, 1, 1));
      // TRI 0/9 with step 20 > range: alternates 0 and 9
      vecs.push_back(mk(1, 1, 2'd0, 0, 9, 20, 5, 1, 0, 0, 0));
      vecs.push_back(idl(1, 2, 1, 0, 0));
      vecs.push_back(idl(1, 0, 0, 1, 1));
      vecs.push_back(idl(1, 9, 1, 0, 1));
      vecs.push_back(idl(1, 0, 0, 1, 1));
      vecs.push_back(idl(1, 9, 1, 0, 1));
      // accept coincides with a boundary: waits for the next one
      vecs.push_back(mk(1, 1, 2'd1, 0, 5, 5, 0, 0, 1, 0, 0));
      vecs.push_back(idl(1, 9, 1, 0, 0));
      vecs.push_back(idl(1, 0, 0, 1, 1));
      vecs.push_back(idl(1, 5, 0, 0, 1));
      vecs.push_back(idl(1, 0, 0, 1, 1));

      foreach (vecs[i]) begin
         en        = vecs[i].en;
         cfg_valid = vecs[i].vld;
         cfg_mode  = vecs[i].mode;
         cfg_lo    = vecs[i].lo;
         cfg_hi    = vecs[i].hi;
         cfg_step  = vecs[i].step;
         step();
         chk($sformatf("vec%0d_wave", i), wave, vecs[i].w);
         chk($sformatf("vec%0d_cd", i), count_down, vecs[i].cd);
         chk($sformatf("vec%0d_pulse", i), period_pulse, vecs[i].p);
         chk($sformatf("vec%0d_ready", i), cfg_ready, vecs[i].rdy);
         chk($sformatf("vec%0d_err", i), cfg_err, vecs[i].err);
      end

      // Reset mid-period with a config pending.
      en = 1'b1;
      cfg_valid = 1'b1; cfg_mode = 2'd0;
      cfg_lo = 8'd30; cfg_hi = 8'd40; cfg_step = 8'd1;
      step();
      chk("pre_rst_wave", wave, 5);
      chk("pre_rst_ready", cfg_ready, 0);
      cfg_valid = 1'b0;
      reset = 1'b1;
      step();
      chk("rst_wave", wave, 0);
      chk("rst_cd", count_down, 0);
      chk("rst_pulse", period_pulse, 0);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_err", cfg_err, 0);
      reset = 1'b0;
      for (int t = 1; t <= 260; t++) begin
         step();
         chk("post_rst_wave", wave, dflt_w(t));
         chk("post_rst_cd", count_down, dflt_cd(t));
         chk("post_rst_pulse", period_pulse, dflt_p(t));
         chk("post_rst_ready", cfg_ready, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
